// File: rtl/pll_reset_sequencer.sv
// Reset sequencer downstream of the system PLL: it pulses the PLL reset, qualifies the
// synchronized lock signal, then releases the system reset and, after a gap, the CPU reset.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned STAGE_GAP_CYCLES    = 8,
   parameter int unsigned CNT_W               = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       cpu_reset_n,
   output logic [2:0] seq_state,
   output logic [7:0] relock_count,
   output logic       lock_lost
);

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      REL_SYS   = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             s1, s2;
   logic             pll_rst_nxt, sys_nxt, cpu_nxt, lost_nxt;
   logic [7:0]       relock_nxt, relock_inc;

   assign seq_state  = state;
   assign relock_inc = (relock_count == 8'hFF) ? relock_count : relock_count + 8'd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= PLL_RST;
         cnt          <= '0;
         s1           <= 1'b0;
         s2           <= 1'b0;
         pll_rst      <= 1'b1;
         sys_reset_n  <= 1'b0;
         cpu_reset_n  <= 1'b0;
         relock_count <= 8'd0;
         lock_lost    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         s1           <= pll_locked;
         s2           <= s1;
         pll_rst      <= pll_rst_nxt;
         sys_reset_n  <= sys_nxt;
         cpu_reset_n  <= cpu_nxt;
         relock_count <= relock_nxt;
         lock_lost    <= lost_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CNT_W'(1);
      pll_rst_nxt = pll_rst;
      sys_nxt     = sys_reset_n;
      cpu_nxt     = cpu_reset_n;
      relock_nxt  = relock_count;
      lost_nxt    = 1'b0;
      case (state)
         PLL_RST: begin
            pll_rst_nxt = 1'b1;
            sys_nxt     = 1'b0;
            cpu_nxt     = 1'b0;
            if (cnt == RST_LAST) begin
               state_nxt   = WAIT_LOCK;
               cnt_nxt     = '0;
               pll_rst_nxt = 1'b0;
            end
         end
         WAIT_LOCK: begin
            if (s2) begin
               state_nxt = STABLE;
               cnt_nxt   = '0;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt   = PLL_RST;
               cnt_nxt     = '0;
               pll_rst_nxt = 1'b1;
               relock_nxt  = relock_inc;
            end
         end
         STABLE: begin
            // Any dropout restarts qualification from scratch, including the timeout.
            if (!s2) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = REL_SYS;
               cnt_nxt   = '0;
               sys_nxt   = 1'b1;
            end
         end
         REL_SYS, RUN: begin
            if (!s2) begin
               state_nxt   = PLL_RST;
               cnt_nxt     = '0;
               pll_rst_nxt = 1'b1;
               sys_nxt     = 1'b0;
               cpu_nxt     = 1'b0;
               lost_nxt    = 1'b1;
               relock_nxt  = relock_inc;
            end else if (state == RUN) begin
               cnt_nxt = cnt;
            end else if (cnt == GAP_LAST) begin
               state_nxt = RUN;
               cpu_nxt   = 1'b1;
            end
         end
         default: begin
            // Illegal encodings fall back to the reset posture but keep the relock history.
            state_nxt   = PLL_RST;
            cnt_nxt     = '0;
            pll_rst_nxt = 1'b1;
            sys_nxt     = 1'b0;
            cpu_nxt     = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters and hand-derived timing.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst, sys_reset_n, cpu_reset_n, lock_lost;
   logic [2:0] seq_state;
   logic [7:0] relock_count;
   int         total = 0;
   int         bad = 0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8),
      .STAGE_GAP_CYCLES(3), .CNT_W(6)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
      .sys_reset_n(sys_reset_n), .cpu_reset_n(cpu_reset_n), .seq_state(seq_state),
      .relock_count(relock_count), .lock_lost(lock_lost)
   );

   always #10 clk = ~clk;

   // Outputs are sampled 1 time unit after the active edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset for one edge, then run through the 4-edge PLL reset pulse into WAIT_LOCK.
   task automatic do_reset();
      reset_n = 1'b0;
      pll_locked = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (pll_rst !== (i < 4) || seq_state !== ((i < 4) ? 3'd0 : 3'd1)) begin
            bad++;
            $display("FAIL pll_rst_pulse edge=%0d got pll_rst=%b state=%0d want pll_rst=%b", i, pll_rst, seq_state, (i < 4));
         end
      end
   endtask

   // From WAIT_LOCK: raise lock, first sampled at edge k, and follow it into RUN.
   task automatic check_release(input string name, input logic [7:0] exp_relock);
      pll_locked = 1'b1;
      tick();
      for (int i = 1; i <= 13; i++) begin
         logic [2:0] es;
         tick();
         es = (i < 2) ? 3'd1 : (i < 10) ? 3'd2 : (i < 13) ? 3'd3 : 3'd4;
         total++;
         if (seq_state !== es || sys_reset_n !== (i >= 10) || cpu_reset_n !== (i >= 13) ||
             pll_rst !== 1'b0 || lock_lost !== 1'b0 || relock_count !== exp_relock) begin
            bad++;
            $display("FAIL %s k+%0d got state=%0d sys=%b cpu=%b pll=%b lost=%b rc=%0d want state=%0d sys=%b cpu=%b rc=%0d",
                     name, i, seq_state, sys_reset_n, cpu_reset_n, pll_rst, lock_lost, relock_count,
                     es, (i >= 10), (i >= 13), exp_relock);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      pll_locked = 1'b0;
      tick();
      tick();
      total++;
      if ({pll_rst, sys_reset_n, cpu_reset_n, lock_lost} !== 4'b1000 || seq_state !== 3'd0 || relock_count !== 8'd0) begin
         bad++;
         $display("FAIL reset_values got pll=%b sys=%b cpu=%b lost=%b state=%0d rc=%0d want 1 0 0 0 0 0",
                  pll_rst, sys_reset_n, cpu_reset_n, lock_lost, seq_state, relock_count);
      end
      do_reset();
      check_release("startup", 8'd0);
   endtask

   task automatic test_glitch();
      do_reset();
      pll_locked = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      total++;
      if (seq_state !== 3'd2) begin
         bad++;
         $display("FAIL glitch_pre got state=%0d want 2", seq_state);
      end
      for (int i = 1; i <= 10; i++) begin
         logic [2:0] es;
         tick();
         es = (i == 1) ? 3'd1 : (i < 10) ? 3'd2 : 3'd3;
         total++;
         if (seq_state !== es || sys_reset_n !== (i == 10) || lock_lost !== 1'b0) begin
            bad++;
            $display("FAIL glitch k+%0d got state=%0d sys=%b lost=%b want state=%0d sys=%b lost=0",
                     i, seq_state, sys_reset_n, lock_lost, es, (i == 10));
         end
      end
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (seq_state !== 3'd4 || cpu_reset_n !== 1'b1) begin
         bad++;
         $display("FAIL glitch_run got state=%0d cpu=%b want 4 1", seq_state, cpu_reset_n);
      end
   endtask

   task automatic test_lock_loss();
      pll_locked = 1'b0;
      for (int i = 0; i <= 3; i++) begin
         logic ex;
         tick();
         ex = (i == 2);
         total++;
         if (lock_lost !== ex || sys_reset_n !== (i < 2) || cpu_reset_n !== (i < 2) || pll_rst !== (i >= 2) ||
             seq_state !== ((i < 2) ? 3'd4 : 3'd0) || relock_count !== ((i < 2) ? 8'd0 : 8'd1)) begin
            bad++;
            $display("FAIL lock_loss k+%0d got lost=%b sys=%b cpu=%b pll=%b state=%0d rc=%0d want lost=%b",
                     i, lock_lost, sys_reset_n, cpu_reset_n, pll_rst, seq_state, relock_count, ex);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int r = 1; r <= 2; r++) begin
         for (int i = 1; i <= 36; i++) begin
            logic ep;
            tick();
            ep = (i >= 32 && i < 36);
            total++;
            if (pll_rst !== ep || seq_state !== (ep ? 3'd0 : 3'd1) ||
                relock_count !== ((i >= 32) ? 8'(r) : 8'(r - 1))) begin
               bad++;
               $display("FAIL timeout r=%0d e=%0d got pll=%b state=%0d rc=%0d want pll=%b rc=%0d",
                        r, i, pll_rst, seq_state, relock_count, ep, (i >= 32) ? r : r - 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 36; i++) tick();
      pll_locked = 1'b1;
      tick();
      for (int i = 1; i <= 11; i++) tick();
      total++;
      if (seq_state !== 3'd3 || relock_count !== 8'd1) begin
         bad++;
         $display("FAIL mid_pre got state=%0d rc=%0d want 3 1", seq_state, relock_count);
      end
      reset_n = 1'b0;
      pll_locked = 1'b0;
      tick();
      total++;
      if ({pll_rst, sys_reset_n, cpu_reset_n, lock_lost} !== 4'b1000 || seq_state !== 3'd0 || relock_count !== 8'd0) begin
         bad++;
         $display("FAIL mid_reset got pll=%b sys=%b cpu=%b lost=%b state=%0d rc=%0d want 1 0 0 0 0 0",
                  pll_rst, sys_reset_n, cpu_reset_n, lock_lost, seq_state, relock_count);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_release("after_mid_reset", 8'd0);
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 255 * 36; i++) tick();
      total++;
      if (relock_count !== 8'd255 || seq_state !== 3'd1) begin
         bad++;
         $display("FAIL sat_255 got rc=%0d state=%0d want 255 1", relock_count, seq_state);
      end
      for (int i = 0; i < 5 * 36; i++) tick();
      total++;
      if (relock_count !== 8'd255 || seq_state !== 3'd1) begin
         bad++;
         $display("FAIL sat_260 got rc=%0d state=%0d want 255 1", relock_count, seq_state);
      end
      check_release("after_saturate", 8'd255);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_lock_loss();
      test_timeout();
      test_reset_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
